// File: rtl/rst_seq_eth.sv
// Ethernet reset sequencer: pulses the MMCM reset, qualifies lock, then releases NUM_CH domains staggered.
// Optional ETH_RST_SEQ_RETRY_EN: a WAIT_LOCK timeout re-pulses the MMCM reset instead of waiting forever.
module rst_seq_eth #(
    parameter int NUM_CH           = 3,
    parameter int SYNC_STAGES      = 2,
    parameter int MMCM_RST_CYC     = 8,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int STAGGER_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              locked_in,
    input  logic              sw_rst_in,
    output logic              mmcm_rst_out,
    output logic [NUM_CH-1:0] rst_out,
    output logic              all_ready_out,
    output logic [2:0]        state_out,
    output logic [7:0]        lock_loss_cnt_out,
    output logic              timeout_out
);
    localparam int REL_CYC = NUM_CH * STAGGER_CYC;
    localparam int MAX_AB  = (MMCM_RST_CYC > LOCK_STABLE_CYC) ? MMCM_RST_CYC : LOCK_STABLE_CYC;
    localparam int MAX_CD  = (REL_CYC > LOCK_TIMEOUT_CYC) ? REL_CYC : LOCK_TIMEOUT_CYC;
    localparam int CNT_MAX = ((MAX_AB > MAX_CD) ? MAX_AB : MAX_CD) - 1;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        MMCM_RST  = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_sync;
    logic                   timeout_nxt;
    logic [7:0]             loss_nxt;
    logic [NUM_CH-1:0]      rst_nxt;

    assign locked_sync = sync[SYNC_STAGES-1];
    assign state_out   = state;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_nxt = timeout_out;
        loss_nxt    = lock_loss_cnt_out;
        case (state)
            MMCM_RST: begin
                if (cnt == CW'(MMCM_RST_CYC - 1)) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_sync) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT_CYC - 1)) begin
                    // counter parks at its limit so it never wraps
                    timeout_nxt = 1'b1;
`ifdef ETH_RST_SEQ_RETRY_EN
                    state_nxt = MMCM_RST;
                    cnt_nxt   = '0;
`else
                    cnt_nxt   = cnt;
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STABLE: begin
                if (!locked_sync) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(LOCK_STABLE_CYC - 1)) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RELEASE, RUN: begin
                // lock loss has priority over a software request
                if (!locked_sync) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                    if (lock_loss_cnt_out != 8'hFF) loss_nxt = lock_loss_cnt_out + 8'd1;
                end else if (sw_rst_in) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (state == RELEASE) begin
                    if (cnt == CW'(REL_CYC - 1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = MMCM_RST;
                cnt_nxt   = '0;
            end
        endcase

        // channel i drops once the RELEASE count reaches (i+1)*STAGGER_CYC
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_nxt == RUN)
                rst_nxt[i] = 1'b0;
            else if (state_nxt == RELEASE)
                rst_nxt[i] = (int'(cnt_nxt) < (i + 1) * STAGGER_CYC);
            else
                rst_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync              <= '0;
            state             <= MMCM_RST;
            cnt               <= '0;
            mmcm_rst_out      <= 1'b1;
            rst_out           <= '1;
            all_ready_out     <= 1'b0;
            lock_loss_cnt_out <= '0;
            timeout_out       <= 1'b0;
        end else begin
            sync              <= {sync[SYNC_STAGES-2:0], locked_in};
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            mmcm_rst_out      <= (state_nxt == MMCM_RST);
            rst_out           <= rst_nxt;
            all_ready_out     <= (state_nxt == RUN);
            lock_loss_cnt_out <= loss_nxt;
            timeout_out       <= timeout_nxt;
        end
    end
endmodule
